program_loader: RTL
===================

# program_loader

Boot-time program loader sitting directly upstream of the RISC CPU core and its 32×8 program/data memory. It accepts a byte stream over a valid/ready handshake and writes it into consecutive memory addresses starting at 0. It holds the CPU in reset until the full image is written, then releases it. It also watches the CPU `halt` output and counts the cycles of each run.

## Interface
Parameters:
- `ADDR_W`, default 5. Memory address width; image length is 2^ADDR_W bytes.
- `DATA_W`, default 8. Byte width of the stream and memory data.
- `CNT_W`, default 16. Width of the run-cycle counter.

Ports:
- `clk`  in  1  System clock. All logic is rising-edge.
- `rst`  in  1  Asynchronous, active-high reset.
- `start`  in  1  Single-cycle pulse that begins a load.
- `in_valid`  in  1  Stream byte valid.
- `in_data`  in  DATA_W  Stream byte.
- `in_ready`  out  1  Loader accepts a byte this cycle.
- `mem_addr`  out  ADDR_W  Memory write address.
- `mem_data`  out  DATA_W  Memory write data.
- `mem_wr`  out  1  Memory write enable, one cycle per byte.
- `cpu_rst`  out  1  Reset to the CPU, active-high.
- `cpu_halt`  in  1  `halt` from the CPU.
- `load_done`  out  1  Image loaded; CPU running or halted.
- `load_err`  out  1  Checksum failure (see Configuration).
- `run_cycles`  out  CNT_W  Cycles spent in RUN.

## Operation
- States: IDLE, LOAD, CHECK (only with the macro), SETTLE, RUN, HALTED, ERROR (only with the macro).
- IDLE:
  - `cpu_rst`=1, `in_ready`=0.
  - `start` → LOAD. Entering LOAD clears the byte counter and `run_cycles` to 0.
- LOAD:
  - `in_ready`=1.
  - Each beat (`in_valid`&&`in_ready` at an edge) registers `mem_addr`=counter and `mem_data`=`in_data`, asserts `mem_wr` for the following cycle, and increments the counter.
  - The beat at counter = 2^ADDR_W−1 is the last one. It moves to CHECK with the macro, or to SETTLE without it.
  - The counter wraps to 0 after the last beat.
- SETTLE: lasts exactly one cycle. The final `mem_wr` completes here while `cpu_rst` is still 1. Then → RUN.
- RUN:
  - `cpu_rst`=0, `load_done`=1.
  - `run_cycles` increments each cycle and saturates at all-ones.
  - `cpu_halt`=1 → HALTED.
- HALTED:
  - `cpu_rst`=0, `load_done`=1.
  - `run_cycles` holds its value.
- `start` is ignored in LOAD, CHECK and SETTLE.
- `start` in RUN, HALTED or ERROR restarts the load: → LOAD, and `cpu_rst` returns to 1 on the same edge.
- If `start` and `cpu_halt` are both high in RUN, `start` wins.
- `cpu_rst` and `load_done` are decoded from the state register only, so they are glitch-free.
- `mem_wr` is low in every state except the cycle after a beat.

## Timing
- Reset values: state IDLE, `in_ready`=0, `mem_addr`=0, `mem_data`=0, `mem_wr`=0, `cpu_rst`=1, `load_done`=0, `load_err`=0, `run_cycles`=0, counter=0.
- Reset asserted mid-operation aborts immediately. Memory contents are not cleared.
- Write latency: one cycle from beat edge to `mem_wr` high.
- `in_ready` depends on state only, never on `in_valid`.
- `in_valid` may be held high across cycles; one byte is taken per cycle.
- Minimum time from `start` to `cpu_rst` falling (no macro): 1 cycle to enter LOAD, 2^ADDR_W beat cycles, 1 SETTLE cycle. That is 34 cycles from the `start` edge with back-to-back beats.
- `cpu_halt` is sampled in RUN only, and takes effect one edge later.

## Configuration
- Macro: `PROGRAM_LOADER_CHECKSUM_EN`.
- Defined:
  - After the last image byte, the loader enters CHECK with `in_ready`=1 and accepts one extra checksum byte. That byte is not written to memory.
  - If the 8-bit modulo-256 sum of all image bytes plus the checksum byte is 0x00 → SETTLE.
  - Otherwise → ERROR: `load_err`=1, `cpu_rst`=1, `load_done`=0, `in_ready`=0.
  - `load_err` is cleared on entering LOAD.
- Undefined: CHECK and ERROR do not exist, no sum logic is built, and `load_err` is tied to 0.

## Test plan
- Reset, then `start`, then 32 back-to-back bytes 0x00..0x1F. Required: `mem_wr` pulses at addresses 0..31 with data equal to address. `cpu_rst` falls exactly 34 cycles after the `start` edge. `load_done`=1.
- `in_valid` toggled every other cycle during LOAD. Required: exactly 32 writes, no duplicates or gaps, and `in_ready` unaffected.
- Raise `cpu_halt` 100 cycles after `cpu_rst` falls. Required: `run_cycles`=100 and holds; a later `start` clears it to 0 and raises `cpu_rst`.
- Assert `rst` at beat 10, then `start` and load a full image. Required: all outputs at reset values after `rst`; the new image writes begin at address 0.
- With `CNT_W`=4, hold RUN for 20 cycles. Required: `run_cycles` saturates at 0xF.
- With `PROGRAM_LOADER_CHECKSUM_EN` defined: bytes 0x00..0x1F (sum 0xF0) plus checksum 0x10 → RUN. The same image plus checksum 0x11 → `load_err`=1, `cpu_rst` stays 1; a following `start` clears `load_err`.

Source files
------------

// File: rtl/program_loader.sv
// program_loader: boot-time loader between a byte stream and the CPU program memory.
// Writes 2^ADDR_W consecutive bytes from address 0, holds the CPU in reset until
// the image is in memory, then releases it and counts run cycles until halt.
// Optional feature macro: PROGRAM_LOADER_CHECKSUM_EN (trailing mod-2^DATA_W checksum byte).
module program_loader #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wr,
    output logic              cpu_rst,
    input  logic              cpu_halt,
    output logic              load_done,
    output logic              load_err,
    output logic [CNT_W-1:0]  run_cycles
);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_CHECK, S_SETTLE, S_RUN, S_HALTED, S_ERROR
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_SETTLE, S_RUN, S_HALTED
    } state_t;
`endif

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_data_q, mem_data_d;
    logic              mem_wr_q, mem_wr_d;
    logic [CNT_W-1:0]  run_cycles_q, run_cycles_d;
    logic              beat;
    logic              go_load;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] sum_q, sum_d;
    logic [DATA_W-1:0] sum_next;
`endif

    // State-only decodes keep cpu_rst / load_done / in_ready glitch-free.
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    assign in_ready = (state_q == S_LOAD) || (state_q == S_CHECK);
    assign load_err = (state_q == S_ERROR);
`else
    assign in_ready = (state_q == S_LOAD);
    assign load_err = 1'b0;
`endif
    assign load_done  = (state_q == S_RUN) || (state_q == S_HALTED);
    assign cpu_rst    = !load_done;
    assign beat       = in_valid && in_ready;
    assign mem_addr   = mem_addr_q;
    assign mem_data   = mem_data_q;
    assign mem_wr     = mem_wr_q;
    assign run_cycles = run_cycles_q;

    // Next-state, write-port and run-counter logic.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        mem_addr_d   = mem_addr_q;
        mem_data_d   = mem_data_q;
        mem_wr_d     = 1'b0;
        run_cycles_d = run_cycles_q;
        go_load      = 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        sum_d        = sum_q;
        sum_next     = sum_q + in_data;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) go_load = 1'b1;
            end
            S_LOAD: begin
                if (beat) begin
                    mem_addr_d = cnt_q;
                    mem_data_d = in_data;
                    mem_wr_d   = 1'b1;
                    cnt_d      = cnt_q + 1'b1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    sum_d      = sum_next;
                    if (cnt_q == '1) state_d = S_CHECK;
`else
                    if (cnt_q == '1) state_d = S_SETTLE;
`endif
                end
            end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            S_CHECK: begin
                // The checksum byte is consumed but never written to memory.
                if (beat) state_d = (sum_next == '0) ? S_SETTLE : S_ERROR;
            end
            S_ERROR: begin
                if (start) go_load = 1'b1;
            end
`endif
            S_SETTLE: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                // A restart takes priority over a simultaneous halt.
                if (start) begin
                    go_load = 1'b1;
                end else begin
                    if (run_cycles_q != '1) run_cycles_d = run_cycles_q + 1'b1;
                    if (cpu_halt) state_d = S_HALTED;
                end
            end
            S_HALTED: begin
                if (start) go_load = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (go_load) begin
            state_d      = S_LOAD;
            cnt_d        = '0;
            run_cycles_d = '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            sum_d        = '0;
`endif
        end
    end

    // State and datapath registers, asynchronously reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
            mem_wr_q     <= 1'b0;
            run_cycles_q <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            sum_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
            mem_wr_q     <= mem_wr_d;
            run_cycles_q <= run_cycles_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            sum_q        <= sum_d;
`endif
        end
    end

endmodule
